// File: rtl/wshb_frame_reader.sv
// Wishbone classic-cycle master that fetches a linear framebuffer, one 32-bit
// word per pixel, and streams it out through a small FIFO on a valid/ready port.
module wshb_frame_reader #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    // Wishbone master
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic [31:0] wb_dat_sm,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_rty,
    // Pixel stream
    output logic [23:0] pix_data,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready,
    // Status
    output logic        frame_done,
    output logic [7:0]  err_count
);

    localparam int unsigned NPIX  = HDISP * VDISP;
    localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] FETCH_LIMIT = CNT_W'(FIFO_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    typedef struct packed {
        logic        sof;
        logic [23:0] rgb;
    } fifo_entry_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_pix_idx;
    logic [7:0]         r_err_count;
    logic               r_frame_done;

    fifo_entry_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_bus_req;
    logic               w_accept;
    logic               w_last_idx;
    logic               w_last_accept;
    logic               w_push;
    logic               w_pop;
    fifo_entry_t        w_head;
    logic               w_unused;

    // Requests stop one entry short of full so that an ack can always be stored.
    assign w_bus_req     = (r_state == S_FETCH) && (r_count < FETCH_LIMIT);
    assign w_accept      = w_bus_req && wb_ack && !wb_err && !wb_rty;
    assign w_last_idx    = (r_pix_idx == LAST_IDX);
    assign w_last_accept = w_accept && w_last_idx;

    assign wb_cyc = w_bus_req;
    assign wb_stb = w_bus_req;
    assign wb_we  = 1'b0;
    assign wb_sel = 4'hF;
    assign wb_cti = 3'b000;
    assign wb_bte = 2'b00;
    assign wb_adr = BASE_ADDR + (32'(r_pix_idx) << 2);

    assign w_unused = ^wb_dat_sm[31:24];

    // ------------------------------------------------------------------
    // Frame sequencing
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with <= so every register samples the
    // pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_last_accept && !enable) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // pix_idx is already zero whenever the FSM sits in IDLE.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pix_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_accept;
            if (w_accept) begin
                r_pix_idx <= w_last_idx ? '0 : r_pix_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_err_count <= 8'd0;
        end else if (w_bus_req && wb_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign frame_done = r_frame_done;
    assign err_count  = r_err_count;

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    assign w_push = w_accept;
    assign w_pop  = pix_valid && pix_ready;

    // NOTE: the storage array has no reset; only pointers and count do, and
    // pix_valid masks whatever the array holds after reset.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{sof: (r_pix_idx == '0), rgb: wb_dat_sm[23:0]};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The head slot is never rewritten while occupied, so the stream holds
    // steady under backpressure.
    assign w_head    = r_mem[r_rd_ptr];
    assign pix_valid = (r_count != '0);
    assign pix_data  = w_head.rgb;
    assign pix_sof   = w_head.sof;

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader: a queue-based frame/FIFO model checked
// every cycle, plus literal expectations for each scenario.
module tb_wshb_frame_reader;

    localparam int unsigned HDISP      = 4;
    localparam int unsigned VDISP      = 2;
    localparam logic [31:0] BASE_ADDR  = 32'h100;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int          NPIX       = HDISP * VDISP;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        enable    = 1'b0;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_sm;
    logic        wb_ack    = 1'b0;
    logic        wb_err    = 1'b0;
    logic        wb_rty    = 1'b0;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        frame_done;
    logic [7:0]  err_count;

    int checks   = 0;
    int failures = 0;

    wshb_frame_reader #(
        .HDISP      (HDISP),
        .VDISP      (VDISP),
        .BASE_ADDR  (BASE_ADDR),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .enable     (enable),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_adr     (wb_adr),
        .wb_sel     (wb_sel),
        .wb_cti     (wb_cti),
        .wb_bte     (wb_bte),
        .wb_dat_sm  (wb_dat_sm),
        .wb_ack     (wb_ack),
        .wb_err     (wb_err),
        .wb_rty     (wb_rty),
        .pix_data   (pix_data),
        .pix_sof    (pix_sof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .frame_done (frame_done),
        .err_count  (err_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Slave memory content: each word encodes its own address.
    assign wb_dat_sm = {8'hC3, ~wb_adr[23:0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: frame position, run flag, pixel queue, error tally
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        sof;
        logic [23:0] rgb;
    } pix_t;

    pix_t        m_q[$];
    int          m_idx    = 0;
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_err    = 0;
    bit          m_pop;
    bit          m_push;
    bit          m_stb;
    pix_t        m_item;
    logic [31:0] m_addr;

    logic [31:0] acc_log[$];
    int          done_pulses = 0;

    function automatic logic [31:0] addr_of(input int idx);
        return BASE_ADDR + 32'(idx) * 32'd4;
    endfunction

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            m_q.delete();
            m_idx    = 0;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_err    = 0;
        end
        m_addr = addr_of(m_idx);
        m_stb  = m_active && (m_q.size() < FIFO_DEPTH - 1);

        check("wb_cyc", 32'(wb_cyc), 32'(m_stb));
        check("wb_stb", 32'(wb_stb), 32'(m_stb));
        check("wb_adr", wb_adr, m_addr);
        check("wb_const", 32'({wb_we, wb_sel, wb_cti, wb_bte}), 32'({1'b0, 4'hF, 3'b000, 2'b00}));
        check("pix_valid", 32'(pix_valid), 32'(m_q.size() != 0));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("err_count", 32'(err_count), 32'(m_err));
        if (m_q.size() != 0) begin
            check("pix_data", 32'(pix_data), 32'(m_q[0].rgb));
            check("pix_sof", 32'(pix_sof), 32'(m_q[0].sof));
        end
        if (frame_done) done_pulses++;

        if (!sys_rst) begin
            if (wb_stb && wb_ack && !wb_err && !wb_rty) acc_log.push_back(wb_adr);
            m_pop  = (m_q.size() != 0) && pix_ready;
            m_push = 1'b0;
            m_done = 1'b0;
            if (!m_active) begin
                if (enable) m_active = 1'b1;
            end else if (m_stb) begin
                if (wb_err) begin
                    if (m_err < 255) m_err++;
                end else if (!wb_rty && wb_ack) begin
                    m_push = 1'b1;
                    m_item = '{sof: (m_idx == 0), rgb: ~m_addr[23:0]};
                    if (m_idx == NPIX - 1) begin
                        m_idx  = 0;
                        m_done = 1'b1;
                        if (!enable) m_active = 1'b0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(m_item);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset(input logic en);
        sys_rst = 1'b1;
        enable  = en;
        step(2);
        sys_rst = 1'b0;
    endtask

    task automatic wait_stb(input string name);
        int k = 0;
        while (!wb_stb && k < 50) begin
            step(1);
            k++;
        end
        check(name, 32'(wb_stb), 32'd1);
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (acc_log.size() < n && k < 100) begin
            step(1);
            k++;
        end
        check(name, 32'(acc_log.size()), 32'(n));
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (pix_valid && k < 100) begin
            step(1);
            k++;
        end
        check(name, 32'(pix_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(2);
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_adr", wb_adr, 32'h100);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);

        // Zero-wait slave, full frame and wrap into the next one
        acc_log.delete();
        done_pulses = 0;
        enable      = 1'b1;
        wb_ack      = 1'b1;
        sys_rst     = 1'b0;
        wait_log(9, "t1_nine_acks");
        for (int i = 0; i < 8; i++) begin
            if (acc_log.size() > i) check("t1_addr_seq", acc_log[i], 32'h100 + 32'(i) * 32'd4);
        end
        if (acc_log.size() > 8) check("t1_restart", acc_log[8], 32'h100);
        check("t1_done_once", 32'(done_pulses), 32'd1);

        // Backpressure: FIFO_DEPTH-1 words, then the bus pauses
        wb_ack = 1'b0;
        wait_drain("t2_drain");
        acc_log.delete();
        pix_ready = 1'b0;
        wb_ack    = 1'b1;
        step(12);
        check("t2_seven_acks", 32'(acc_log.size()), 32'd7);
        check("t2_stb_paused", 32'(wb_stb), 32'd0);
        check("t2_valid_held", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        step(1);
        check("t2_stb_resume", 32'(wb_stb), 32'd1);
        step(10);

        // Error on the 3rd transfer, then error saturation
        wb_ack = 1'b1;
        do_reset(1'b1);
        acc_log.delete();
        wait_stb("t3_stb");
        step(2);
        check("t3_err_addr", wb_adr, 32'h108);
        wb_err = 1'b1;
        step(1);
        wb_err = 1'b0;
        check("t3_retry_addr", wb_adr, 32'h108);
        check("t3_err_one", 32'(err_count), 32'd1);
        step(2);
        check("t3_log_len", 32'(acc_log.size()), 32'd4);
        if (acc_log.size() > 3) begin
            check("t3_log2", acc_log[2], 32'h108);
            check("t3_log3", acc_log[3], 32'h10C);
        end
        wb_err = 1'b1;
        step(300);
        wb_err = 1'b0;
        check("t3_err_sat", 32'(err_count), 32'd255);

        // Retry together with ack
        check("t4_addr_before", wb_adr, 32'h110);
        wb_rty = 1'b1;
        step(1);
        wb_rty = 1'b0;
        check("t4_addr_held", wb_adr, 32'h110);
        check("t4_no_write", 32'(acc_log.size()), 32'd4);
        check("t4_err_same", 32'(err_count), 32'd255);

        // enable dropped mid-frame
        do_reset(1'b1);
        acc_log.delete();
        done_pulses = 0;
        wait_stb("t5_stb");
        wait_log(3, "t5_three");
        enable = 1'b0;
        step(10);
        check("t5_log_len", 32'(acc_log.size()), 32'd8);
        if (acc_log.size() > 7) check("t5_last_addr", acc_log[7], 32'h11C);
        check("t5_done_once", 32'(done_pulses), 32'd1);
        check("t5_idle_cyc", 32'(wb_cyc), 32'd0);
        enable = 1'b1;
        acc_log.delete();
        wait_stb("t5_restart_stb");
        check("t5_restart_adr", wb_adr, 32'h100);
        step(1);
        if (acc_log.size() > 0) check("t5_restart_log", acc_log[0], 32'h100);

        // Async reset with 5 pixels buffered
        do_reset(1'b1);
        pix_ready = 1'b0;
        wb_ack    = 1'b1;
        wait_stb("t6_stb");
        wb_err = 1'b1;
        step(1);
        wb_err = 1'b0;
        acc_log.delete();
        wait_log(5, "t6_five");
        wb_ack = 1'b0;
        check("t6_valid_pre", 32'(pix_valid), 32'd1);
        check("t6_err_pre", 32'(err_count), 32'd1);
        #2;
        sys_rst = 1'b1;
        #1;
        check("t6_async_cyc", 32'(wb_cyc), 32'd0);
        check("t6_async_stb", 32'(wb_stb), 32'd0);
        check("t6_async_valid", 32'(pix_valid), 32'd0);
        check("t6_async_err", 32'(err_count), 32'd0);
        check("t6_async_adr", wb_adr, 32'h100);
        step(1);
        sys_rst   = 1'b0;
        enable    = 1'b1;
        pix_ready = 1'b1;
        wb_ack    = 1'b1;
        acc_log.delete();
        wait_stb("t6_post_stb");
        check("t6_post_adr", wb_adr, 32'h100);
        begin
            int k = 0;
            while (!pix_valid && k < 20) begin
                step(1);
                k++;
            end
        end
        check("t6_post_valid", 32'(pix_valid), 32'd1);
        check("t6_post_sof", 32'(pix_sof), 32'd1);
        check("t6_post_data", 32'(pix_data), 32'h00FF_FEFF);
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
